// File: rtl/cmd_proc_pkg.sv
// Shared types and field widths for the command processor.
// Opcodes, FSM states and the command/ID byte layout.
package cmd_proc_pkg;

   localparam int ID_W = 6;
   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_STOP  = 2'b00,
      OP_GO    = 2'b01,
      OP_RSVD2 = 2'b10,
      OP_RSVD3 = 2'b11
   } opcode_t;

   typedef enum logic {
      IDLE   = 1'b0,
      MOVING = 1'b1
   } state_t;

endpackage

// File: rtl/cmd_proc_if.sv
// Sticky-flag handshakes from the UART receiver and barcode reader.
// Producers assert a ready/valid flag and hold it until the processor pulses the clear.
interface cmd_proc_if;
   import cmd_proc_pkg::*;

   logic                 cmd_rdy;
   logic [7:0]           cmd;
   logic                 clr_cmd_rdy;
   logic                 ID_vld;
   logic [7:0]           ID;
   logic                 clr_ID_vld;

   modport master (
      output cmd_rdy, cmd, ID_vld, ID,
      input  clr_cmd_rdy, clr_ID_vld
   );

   modport slave (
      input  cmd_rdy, cmd, ID_vld, ID,
      output clr_cmd_rdy, clr_ID_vld
   );

endinterface

// File: rtl/cmd_proc_buzz_gen.sv
// Obstacle buzzer: square wave toggling every BUZZ_DIV cycles while en is high.
// Dropping en silences the buzzer and rearms the divider from zero.
module buzz_gen #(
   parameter int BUZZ_DIV = 12500
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic buzz,
   output logic buzz_n
);

   localparam int CW = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BUZZ_DIV - 1);

   logic [CW-1:0] cnt_reg;
   logic          buzz_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg  <= '0;
         buzz_reg <= 1'b0;
      end else if (!en) begin
         cnt_reg  <= '0;
         buzz_reg <= 1'b0;
      end else if (cnt_reg == CNT_LAST) begin
         cnt_reg  <= '0;
         buzz_reg <= ~buzz_reg;
      end else begin
         cnt_reg  <= cnt_reg + 1'b1;
      end
   end

   assign buzz   = buzz_reg;
   assign buzz_n = ~buzz_reg;

endmodule

// File: rtl/cmd_proc.sv
// Command processor: decodes UART commands into stop/go-to-station requests,
// checks barcode station IDs against the destination and drives motion/buzzer.
module cmd_proc
   import cmd_proc_pkg::*;
#(
   parameter int BUZZ_DIV = 12500
) (
   input  logic             clk,
   input  logic             rst_n,
   cmd_proc_if.slave        bus,
   input  logic             OK2Move,
   output logic             go,
   output logic             in_transit,
   output logic             buzz,
   output logic             buzz_n,
   output logic [ID_W-1:0]  dest_ID
);

   state_t          state_reg;
   logic [ID_W-1:0] dest_id_reg;
   opcode_t         op;
   logic            id_match;

   assign op       = opcode_t'(bus.cmd[7:6]);
   assign id_match = (bus.ID[7:6] == 2'b00) && (bus.ID[5:0] == dest_id_reg);

   // Every byte is consumed the cycle it appears; a command shadows a
   // simultaneous ID while moving so the ID is judged against the new target.
   assign bus.clr_cmd_rdy = bus.cmd_rdy;
   assign bus.clr_ID_vld  = bus.ID_vld && ((state_reg == IDLE) || !bus.cmd_rdy);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         dest_id_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.cmd_rdy && op == OP_GO) begin
                  dest_id_reg <= bus.cmd[ID_W-1:0];
                  state_reg   <= MOVING;
               end
            end
            MOVING: begin
               if (bus.cmd_rdy) begin
                  if (op == OP_GO) begin
                     dest_id_reg <= bus.cmd[ID_W-1:0];
                  end else if (op == OP_STOP) begin
                     state_reg <= IDLE;
                  end
               end else if (bus.ID_vld && id_match) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign in_transit = (state_reg == MOVING);
   assign go         = in_transit && OK2Move;
   assign dest_ID    = dest_id_reg;

   buzz_gen #(
      .BUZZ_DIV (BUZZ_DIV)
   ) u_buzz_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (in_transit && !OK2Move),
      .buzz   (buzz),
      .buzz_n (buzz_n)
   );

endmodule

// File: tb/tb_cmd_proc.sv
// Directed bench for cmd_proc with a short buzzer divider.
module tb_cmd_proc;

   logic       clk;
   logic       rst_n;
   logic       OK2Move;
   logic       go;
   logic       in_transit;
   logic       buzz;
   logic       buzz_n;
   logic [5:0] dest_ID;

   int total = 0;
   int bad   = 0;

   cmd_proc_if bus ();

   cmd_proc #(
      .BUZZ_DIV (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .OK2Move    (OK2Move),
      .go         (go),
      .in_transit (in_transit),
      .buzz       (buzz),
      .buzz_n     (buzz_n),
      .dest_ID    (dest_ID)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      OK2Move     = 1'b1;
      bus.cmd_rdy = 1'b0;
      bus.cmd     = 8'h00;
      bus.ID_vld  = 1'b0;
      bus.ID      = 8'h00;
      #12;
      chk("rst_in_transit", in_transit, 0);
      chk("rst_go", go, 0);
      chk("rst_buzz", buzz, 0);
      chk("rst_buzz_n", buzz_n, 1);
      chk("rst_dest", dest_ID, 0);
      rst_n = 1'b1;
      step();

      // GO to station 0x05
      bus.cmd_rdy = 1'b1; bus.cmd = 8'h45; #1;
      chk("go45_clr_cmd", bus.clr_cmd_rdy, 1);
      chk("go45_clr_id", bus.clr_ID_vld, 0);
      chk("go45_pre_transit", in_transit, 0);
      step();
      bus.cmd_rdy = 1'b0; #1;
      chk("go45_dest", dest_ID, 8'h05);
      chk("go45_transit", in_transit, 1);
      chk("go45_go", go, 1);
      chk("go45_clr_cmd_low", bus.clr_cmd_rdy, 0);

      // Non-matching ID
      bus.ID_vld = 1'b1; bus.ID = 8'h03; #1;
      chk("id03_clr", bus.clr_ID_vld, 1);
      step();
      bus.ID_vld = 1'b0;
      chk("id03_transit", in_transit, 1);

      // Matching low bits but bad upper bits
      bus.ID_vld = 1'b1; bus.ID = 8'h45; #1;
      chk("id45_clr", bus.clr_ID_vld, 1);
      step();
      bus.ID_vld = 1'b0;
      chk("id45_transit", in_transit, 1);

      // Arrival
      bus.ID_vld = 1'b1; bus.ID = 8'h05; #1;
      chk("id05_clr", bus.clr_ID_vld, 1);
      chk("id05_pre_transit", in_transit, 1);
      step();
      bus.ID_vld = 1'b0; #1;
      chk("id05_transit", in_transit, 0);
      chk("id05_go", go, 0);

      // Invalid command in IDLE
      bus.cmd_rdy = 1'b1; bus.cmd = 8'hC7; #1;
      chk("c7_clr_cmd", bus.clr_cmd_rdy, 1);
      step();
      bus.cmd_rdy = 1'b0;
      chk("c7_transit", in_transit, 0);
      chk("c7_dest", dest_ID, 8'h05);

      // ID in IDLE is discarded
      bus.ID_vld = 1'b1; bus.ID = 8'h05; #1;
      chk("idle_id_clr", bus.clr_ID_vld, 1);
      step();
      bus.ID_vld = 1'b0;
      chk("idle_id_transit", in_transit, 0);

      // GO 0x10 then STOP
      bus.cmd_rdy = 1'b1; bus.cmd = 8'h50;
      step();
      chk("go50_transit", in_transit, 1);
      chk("go50_dest", dest_ID, 8'h10);
      bus.cmd = 8'h00;
      step();
      bus.cmd_rdy = 1'b0;
      chk("stop_transit", in_transit, 0);
      chk("stop_dest", dest_ID, 8'h10);

      // Simultaneous retarget command and ID while moving
      bus.cmd_rdy = 1'b1; bus.cmd = 8'h45;
      step();
      bus.cmd = 8'h4A; bus.ID_vld = 1'b1; bus.ID = 8'h0A; #1;
      chk("sim_clr_cmd", bus.clr_cmd_rdy, 1);
      chk("sim_clr_id", bus.clr_ID_vld, 0);
      step();
      bus.cmd_rdy = 1'b0; #1;
      chk("sim_dest", dest_ID, 8'h0A);
      chk("sim_clr_id_next", bus.clr_ID_vld, 1);
      chk("sim_transit_hold", in_transit, 1);
      step();
      bus.ID_vld = 1'b0;
      chk("sim_arrived", in_transit, 0);

      // Buzzer with obstacle
      bus.cmd_rdy = 1'b1; bus.cmd = 8'h45;
      step();
      bus.cmd_rdy = 1'b0;
      OK2Move = 1'b0; #1;
      chk("obs_go", go, 0);
      chk("obs_buzz0", buzz, 0);
      step(); step(); step();
      chk("obs_buzz3", buzz, 0);
      step();
      chk("obs_buzz4", buzz, 1);
      chk("obs_buzz_n4", buzz_n, 0);
      step(); step(); step();
      chk("obs_buzz7", buzz, 1);
      step();
      chk("obs_buzz8", buzz, 0);
      chk("obs_buzz_n8", buzz_n, 1);
      step(); step(); step(); step();
      chk("obs_buzz12", buzz, 1);
      OK2Move = 1'b1; #1;
      chk("clear_go", go, 1);
      step();
      chk("clear_buzz", buzz, 0);
      chk("clear_buzz_n", buzz_n, 1);

      // Asynchronous reset mid-trip while buzzing
      bus.cmd_rdy = 1'b1; bus.cmd = 8'h4C;
      step();
      bus.cmd_rdy = 1'b0;
      OK2Move = 1'b0;
      step(); step(); step(); step();
      chk("pre_rst_buzz", buzz, 1);
      chk("pre_rst_dest", dest_ID, 8'h0C);
      #2 rst_n = 1'b0; #1;
      chk("mid_rst_transit", in_transit, 0);
      chk("mid_rst_go", go, 0);
      chk("mid_rst_buzz", buzz, 0);
      chk("mid_rst_buzz_n", buzz_n, 1);
      chk("mid_rst_dest", dest_ID, 0);
      OK2Move = 1'b1;
      bus.cmd_rdy = 1'b1; bus.cmd = 8'h47;
      step();
      chk("in_rst_transit", in_transit, 0);
      rst_n = 1'b1;
      step();
      bus.cmd_rdy = 1'b0;
      chk("post_rst_transit", in_transit, 1);
      chk("post_rst_dest", dest_ID, 8'h07);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cmd_proc.md
Name: cmd_proc

Overview:
- Command processor directly downstream of the UART receiver.
- Consumes each received command byte (rdy/cmd) and acknowledges it with a clear pulse.
- Decodes the byte into stop / go-to-station requests and tracks the destination station ID.
- Compares station IDs from the barcode reader against the destination, drives the go/in_transit outputs to motion control, and generates the obstacle buzzer.

Parameters:
BUZZ_DIV, 12500, clk cycles per buzzer half-period (2 kHz tone at 50 MHz).

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
cmd_rdy  in  1  sticky ready flag from UART receiver
cmd  in  8  received command byte, valid while cmd_rdy=1
clr_cmd_rdy  out  1  one-cycle acknowledge to UART receiver
ID_vld  in  1  sticky valid flag from barcode reader
ID  in  8  station ID byte, valid while ID_vld=1
clr_ID_vld  out  1  one-cycle acknowledge to barcode reader
OK2Move  in  1  1 = path clear of obstacles
go  out  1  motion enable
in_transit  out  1  1 while a go-to command is active
buzz  out  1  buzzer drive
buzz_n  out  1  complement of buzz
dest_ID  out  6  latched destination station

Behaviour:
- Clock and reset are decided: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, dest_ID=0, in_transit=0, go=0, buzz=0, buzz_n=1, buzz counter=0.
- Command format:
  - cmd[7:6]=2'b00: STOP.
  - cmd[7:6]=2'b01: GO; cmd[5:0] is the destination.
  - 2'b10 and 2'b11: invalid. Consumed and ignored; no state change.
- clr_cmd_rdy is combinational: high in every cycle where cmd_rdy=1, in any state. Consequences:
  - Exactly one consumption per byte.
  - The decode acts on cmd in that same cycle.
- States:
  - IDLE:
    - GO: dest_ID<=cmd[5:0], next MOVING.
    - STOP or invalid: stay IDLE.
    - ID_vld=1: clr_ID_vld=1, ID discarded.
  - MOVING:
    - GO: dest_ID<=cmd[5:0], stay MOVING (retarget mid-trip).
    - STOP: next IDLE.
    - ID_vld=1 with no cmd_rdy: clr_ID_vld=1.
      - ID[7:6]==2'b00 and ID[5:0]==dest_ID: next IDLE (arrived).
      - Otherwise stay MOVING.
- Simultaneous cmd_rdy and ID_vld in MOVING:
  - The command has priority.
  - clr_ID_vld stays 0 that cycle, so the ID remains pending.
  - The ID is evaluated the next cycle against the updated dest_ID.
- Outputs:
  - in_transit = (state==MOVING), registered through the state flop.
  - go = in_transit & OK2Move, combinational; it drops in the same cycle OK2Move falls.
  - Latency: GO accepted at edge N gives in_transit=1 after edge N+1. Arrival ID accepted at edge N gives in_transit=0 after edge N+1.
- Buzzer:
  - Active condition is in_transit & !OK2Move.
  - While active, the counter increments each cycle. At BUZZ_DIV-1 it wraps to 0 and buzz toggles.
  - While inactive, counter=0 and buzz=0.
  - buzz_n = ~buzz at all times.
  - Counter width is $clog2(BUZZ_DIV).
- Reset mid-trip: asynchronous return to all reset values. A pending cmd_rdy/ID_vld is handled normally after reset is released.

Decomposition:
- Shared package cmd_proc_pkg holds:
  - opcode_t enum {OP_STOP=2'b00, OP_GO=2'b01, OP_RSVD2, OP_RSVD3}.
  - state_t enum {IDLE, MOVING}.
  - ID field widths: ID_W=6, OP_W=2.
- One sub-module, buzz_gen (clk, rst_n, en, buzz, buzz_n; parameter BUZZ_DIV).
- FSM, decode and ID compare stay in cmd_proc.

Test Plan:
- Reset, then cmd_rdy=1, cmd=8'h45: clr_cmd_rdy=1 that cycle; dest_ID=6'h05; in_transit=1 and go=1 (OK2Move=1) next cycle.
- While moving to 0x05: ID=8'h03 with ID_vld: clr_ID_vld pulses, stays MOVING. Then ID=8'h05: in_transit=0 and go=0 one cycle later. ID=8'h45 (bad upper bits) does not stop the trip.
- While moving: cmd=8'h00 gives IDLE. In IDLE, cmd=8'hC7 is consumed (clr_cmd_rdy=1) and the state stays IDLE with dest_ID unchanged. In IDLE, ID_vld is cleared with no effect.
- cmd_rdy (cmd=8'h4A) and ID_vld (ID=8'h0A) in the same MOVING cycle: only clr_cmd_rdy that cycle. Next cycle clr_ID_vld=1 and the ID matches the new dest 0x0A, so IDLE.
- BUZZ_DIV=4, moving with OK2Move=0: go=0 immediately; buzz toggles every 4 cycles with buzz_n complementary. OK2Move=1 gives buzz=0 and go=1.
- Assert rst_n=0 mid-trip while buzzing: all outputs return to reset values asynchronously; dest_ID=0.
